ascii_bcd_entry: RTL and testbench
==================================

# ascii_bcd_entry

Two-digit decimal entry stage that sits directly upstream of the BCD-to-binary converter. It accepts a stream of 8-bit ASCII characters from a terminal or keypad source over a valid/ready handshake, and edits up to two BCD digits in place. On an enter character it presents the digit pair (`bcd1` tens, `bcd0` units) to the converter over a second valid/ready handshake. It rejects malformed input with a one-cycle error pulse and never presents an empty entry.

## Interface
- `CHAR_ENTER`, default 8'h0D: commits the current entry.
- `CHAR_BKSP`, default 8'h08: deletes the last digit.
- `CHAR_CLEAR`, default 8'h1B: discards the entry.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_char`  in  8  ASCII character.
- `in_valid`  in  1  `in_char` is valid.
- `in_ready`  out  1  block accepts a character this cycle.
- `bcd1`  out  4  tens digit, 0-9.
- `bcd0`  out  4  units digit, 0-9.
- `out_valid`  out  1  `bcd1`/`bcd0` hold a committed entry.
- `out_ready`  in  1  downstream consumes the entry.
- `digit_count`  out  2  digits currently entered, 0-2.
- `err`  out  1  one-cycle pulse flagging a rejected character.

## Operation
- FSM states and their digit counts:
  - IDLE: 0 digits.
  - ONE: 1 digit.
  - TWO: 2 digits.
  - PRESENT: entry committed, waiting for downstream.
- `digit_count` = 0/1/2 in IDLE/ONE/TWO.
- In PRESENT, `digit_count` holds the committed count.
- Accept condition: `in_valid && in_ready`. `in_ready` = (state != PRESENT), decoded combinationally from state.
- Digit characters are 8'h30-8'h39; digit value = `in_char[3:0]`.
- Digit in IDLE or ONE: shift left (`bcd1` <= `bcd0`, `bcd0` <= digit), advance IDLE->ONE or ONE->TWO.
- Digit in TWO: rejected. Pulse `err`; digits and state unchanged.
- `CHAR_BKSP`:
  - In ONE or TWO: shift right (`bcd0` <= `bcd1`, `bcd1` <= 0), count decrements.
  - In IDLE: rejected with `err`.
- `CHAR_CLEAR`: both digits <= 0, state <= IDLE from IDLE/ONE/TWO. No `err`, even when already empty.
- `CHAR_ENTER`:
  - In ONE or TWO: state <= PRESENT.
  - In IDLE: rejected with `err`.
- Any other character: rejected with `err`, no state change.
- Single-digit entry presents `bcd1`=0, `bcd0`=digit, so the downstream value equals the digit.
- PRESENT:
  - `out_valid`=1; `bcd1`/`bcd0` stable until `out_ready`.
  - On `out_valid && out_ready`: digits <= 0, state <= IDLE.
- Invariant: digits are always BCD-legal (0-9); no other values are ever loaded.

## Timing
- Reset (`reset_n` low, asynchronous): state IDLE; `bcd1`=`bcd0`=0; `digit_count`=0; `out_valid`=0; `err`=0.
- `in_ready` reads 1 during reset, but no character is accepted while `reset_n` is low.
- Reset asserted mid-entry or in PRESENT aborts immediately. A pending entry is lost and is never presented.
- Throughput: one character per cycle in IDLE/ONE/TWO.
- Each accepted character updates digits, state and `digit_count` on the same rising edge. The new values are visible the following cycle.
- Latency from accepted `CHAR_ENTER` to `out_valid`=1 is one cycle.
- `in_ready` falls in that same cycle, so a character offered back-to-back after enter is held off.
- `out_valid` stays high until the handshake. On the edge where `out_ready` is sampled high, state returns to IDLE. `in_ready`=1 and `out_valid`=0 take effect the next cycle.
- `err` is registered: high for exactly one cycle, the cycle after the rejected character's accept edge. Consecutive rejected characters give consecutive high cycles.
- `out_ready` is ignored outside PRESENT. `in_valid` is ignored in PRESENT, and the character is not consumed.
- All outputs are driven from registers, except `in_ready`, which is decoded from the state register.

## Test plan
- **Two-digit entry:** reset, then send '4','2',CR with `out_ready`=0 -> `bcd1`=4, `bcd0`=2, `out_valid`=1 one cycle after CR, `in_ready`=0. Then raise `out_ready` -> next cycle `out_valid`=0, digits 0, `digit_count`=0.
- **Single digit and backspace:** '7',CR -> `bcd1`=0, `bcd0`=7. Next entry '9','3',BKSP,'5',CR -> `bcd1`=9, `bcd0`=5.
- **Rejections:** CR in IDLE, BKSP in IDLE, 'A' (8'h41), and a third digit after '1','2' -> `err`=1 for one cycle each; state and digits unchanged; the later CR presents 1,2.
- **Clear:** '8','8',ESC,'3',CR -> presents 0,3; no `err` on ESC.
- **Backpressure:** hold `in_valid`=1 with '6' while in PRESENT for 5 cycles -> not accepted. After the `out_ready` handshake it is accepted the cycle after `in_ready` rises, giving `digit_count`=1, `bcd0`=6.
- **Reset mid-operation:** assert `reset_n` low while in PRESENT with 5,5 -> outputs go to reset values immediately (asynchronously). After release, IDLE with `in_ready`=1 and no `out_valid`.

Source files
------------

// File: rtl/ascii_bcd_entry.sv
// Two-digit ASCII keypad entry that edits a BCD digit pair and hands it to the BCD-to-binary converter.
// Latency: each accepted character takes effect one cycle later; out_valid rises one cycle after ENTER.
// Backpressure: in_ready drops while an entry is presented, and stays low until out_ready completes the handshake.
module ascii_bcd_entry #(
    parameter logic [7:0] CHAR_ENTER = 8'h0D,
    parameter logic [7:0] CHAR_BKSP  = 8'h08,
    parameter logic [7:0] CHAR_CLEAR = 8'h1B
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in_char,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] digit_count,
    output logic       err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ONE     = 2'd1;
    localparam logic [1:0] TWO     = 2'd2;
    localparam logic [1:0] PRESENT = 2'd3;

    logic [1:0] state;
    logic       is_digit;

    assign in_ready = (state != PRESENT);
    assign is_digit = (in_char >= 8'h30) && (in_char <= 8'h39);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bcd1        <= 4'd0;
            bcd0        <= 4'd0;
            digit_count <= 2'd0;
            out_valid   <= 1'b0;
            err         <= 1'b0;
        end else begin
            err <= 1'b0;
            if (state == PRESENT) begin
                if (out_ready) begin
                    state       <= IDLE;
                    bcd1        <= 4'd0;
                    bcd0        <= 4'd0;
                    digit_count <= 2'd0;
                    out_valid   <= 1'b0;
                end
            end else if (in_valid) begin
                // In IDLE/ONE/TWO the state encoding equals the digit count.
                if (is_digit) begin
                    if (state == TWO) begin
                        err <= 1'b1;
                    end else begin
                        bcd1        <= bcd0;
                        bcd0        <= in_char[3:0];
                        state       <= state + 2'd1;
                        digit_count <= digit_count + 2'd1;
                    end
                end else if (in_char == CHAR_BKSP) begin
                    if (state == IDLE) begin
                        err <= 1'b1;
                    end else begin
                        bcd0        <= bcd1;
                        bcd1        <= 4'd0;
                        state       <= state - 2'd1;
                        digit_count <= digit_count - 2'd1;
                    end
                end else if (in_char == CHAR_CLEAR) begin
                    bcd1        <= 4'd0;
                    bcd0        <= 4'd0;
                    state       <= IDLE;
                    digit_count <= 2'd0;
                end else if (in_char == CHAR_ENTER) begin
                    if (state == IDLE) begin
                        err <= 1'b1;
                    end else begin
                        state     <= PRESENT;
                        out_valid <= 1'b1;
                    end
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ascii_bcd_entry.sv
// Directed bench for ascii_bcd_entry: expected digit pairs are queued on ENTER and checked at the handshake.
module tb_ascii_bcd_entry;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_char;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] bcd1;
    logic [3:0] bcd0;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] digit_count;
    logic       err;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    logic [7:0] sb[$];

    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] BS  = 8'h08;
    localparam logic [7:0] ESC = 8'h1B;

    ascii_bcd_entry dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_char     (in_char),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .bcd1        (bcd1),
        .bcd0        (bcd0),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .digit_count (digit_count),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one character for one accept edge and checks err/count at the next negedge.
    task automatic send(input string tag, input logic [7:0] c, input logic e, input logic [1:0] cnt);
        in_char  = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_err"}, 8'(err), 8'(e));
        chk({tag, "_cnt"}, 8'(digit_count), 8'(cnt));
    endtask

    task automatic enter(input string tag, input logic [3:0] b1, input logic [3:0] b0, input logic [1:0] cnt);
        sb.push_back({b1, b0});
        send(tag, CR, 1'b0, cnt);
        chk({tag, "_ovld"}, 8'(out_valid), 8'd1);
        chk({tag, "_irdy"}, 8'(in_ready), 8'd0);
    endtask

    // Waits (bounded) for out_valid, compares against the scoreboard and completes the handshake.
    task automatic consume(input string tag);
        logic [7:0] exp;
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_wait"}, 8'(out_valid), 8'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 8'(out_valid), 8'd0);
        end else begin
            exp = sb.pop_front();
            chk({tag, "_digits"}, {bcd1, bcd0}, exp);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_ovld_low"}, 8'(out_valid), 8'd0);
        chk({tag, "_cleared"}, {bcd1, bcd0}, 8'h00);
        chk({tag, "_cnt0"}, 8'(digit_count), 8'd0);
        chk({tag, "_irdy_hi"}, 8'(in_ready), 8'd1);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_char   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("rst_ovld", 8'(out_valid), 8'd0);
        chk("rst_digits", {bcd1, bcd0}, 8'h00);
        chk("rst_cnt", 8'(digit_count), 8'd0);
        chk("rst_err", 8'(err), 8'd0);
        chk("rst_irdy", 8'(in_ready), 8'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Two-digit entry held without out_ready
        send("d4", 8'h34, 1'b0, 2'd1);
        send("d2", 8'h32, 1'b0, 2'd2);
        chk("42_pre", {bcd1, bcd0}, 8'h42);
        enter("cr42", 4'd4, 4'd2, 2'd2);
        repeat (3) @(negedge clk);
        chk("42_hold_vld", 8'(out_valid), 8'd1);
        chk("42_hold_dig", {bcd1, bcd0}, 8'h42);
        consume("out42");

        // Single digit, then backspace editing
        send("d7", 8'h37, 1'b0, 2'd1);
        enter("cr07", 4'd0, 4'd7, 2'd1);
        consume("out07");
        send("d9", 8'h39, 1'b0, 2'd1);
        send("d3", 8'h33, 1'b0, 2'd2);
        send("bs", BS, 1'b0, 2'd1);
        chk("bs_dig", {bcd1, bcd0}, 8'h09);
        send("d5", 8'h35, 1'b0, 2'd2);
        enter("cr95", 4'd9, 4'd5, 2'd2);
        consume("out95");

        // Rejections pulse err for one cycle each
        send("cr_idle", CR, 1'b1, 2'd0);
        send("bs_idle", BS, 1'b1, 2'd0);
        send("ch_A", 8'h41, 1'b1, 2'd0);
        chk("rej_irdy", 8'(in_ready), 8'd1);
        send("d1", 8'h31, 1'b0, 2'd1);
        send("d2b", 8'h32, 1'b0, 2'd2);
        send("d3_rej", 8'h33, 1'b1, 2'd2);
        chk("rej_dig", {bcd1, bcd0}, 8'h12);
        @(negedge clk);
        chk("err_one_cycle", 8'(err), 8'd0);
        enter("cr12", 4'd1, 4'd2, 2'd2);
        consume("out12");

        // Clear discards without error
        send("d8a", 8'h38, 1'b0, 2'd1);
        send("d8b", 8'h38, 1'b0, 2'd2);
        send("esc", ESC, 1'b0, 2'd0);
        chk("esc_dig", {bcd1, bcd0}, 8'h00);
        send("esc_empty", ESC, 1'b0, 2'd0);
        send("d3c", 8'h33, 1'b0, 2'd1);
        enter("cr03", 4'd0, 4'd3, 2'd1);
        consume("out03");

        // Backpressure: '6' offered during PRESENT is held off
        send("d1bp", 8'h31, 1'b0, 2'd1);
        enter("cr01", 4'd0, 4'd1, 2'd1);
        in_char  = 8'h36;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_irdy", 8'(in_ready), 8'd0);
            chk("bp_hold", {6'd0, digit_count}, 8'd1);
            chk("bp_dig", {bcd1, bcd0}, 8'h01);
        end
        chk("bp_sb", {bcd1, bcd0}, sb.pop_front());
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_ovld_low", 8'(out_valid), 8'd0);
        chk("bp_cnt0", 8'(digit_count), 8'd0);
        chk("bp_irdy_hi", 8'(in_ready), 8'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_acc_cnt", 8'(digit_count), 8'd1);
        chk("bp_acc_dig", {bcd1, bcd0}, 8'h06);
        send("bp_esc", ESC, 1'b0, 2'd0);

        // Reset while presenting 5,5 aborts the entry
        send("d5a", 8'h35, 1'b0, 2'd1);
        send("d5b", 8'h35, 1'b0, 2'd2);
        enter("cr55", 4'd5, 4'd5, 2'd2);
        void'(sb.pop_front());
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_ovld", 8'(out_valid), 8'd0);
        chk("mid_rst_dig", {bcd1, bcd0}, 8'h00);
        chk("mid_rst_cnt", 8'(digit_count), 8'd0);
        chk("mid_rst_irdy", 8'(in_ready), 8'd1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_irdy", 8'(in_ready), 8'd1);
        chk("post_rst_ovld", 8'(out_valid), 8'd0);
        chk("post_rst_sb", 8'(sb.size()), 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
